// File: rtl/dm_pkg.sv
// Shared types and helpers for the dm_responder memory-side responder.
package dm_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dm_state_e;

  // Helpers work on the widest supported word; callers zero-extend and truncate.
  localparam int unsigned DM_MAX_W     = 128;
  localparam int unsigned DM_MAX_LANES = DM_MAX_W / 8;

  localparam logic [DM_MAX_LANES-1:0] WEB_READ = '1;

  function automatic logic [DM_MAX_W-1:0] lane_merge(
    input logic [DM_MAX_W-1:0]     old_w,
    input logic [DM_MAX_W-1:0]     new_w,
    input logic [DM_MAX_LANES-1:0] web
  );
    logic [DM_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(DM_MAX_LANES); i++) begin
      if (!web[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Native CPU memory port (CS/OE/WEB/A/DI/DO) plus the responder ready flag.
interface dm_mem_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int LANES = DATA_W / 8;

  logic              CS;
  logic              OE;
  logic [LANES-1:0]  WEB;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              ready;

  modport master (output CS, OE, WEB, A, DI, input DO, ready);
  modport slave  (input CS, OE, WEB, A, DI, output DO, ready);
endinterface

// File: rtl/dm_rd_pipe.sv
// Fixed-depth read-data delay line; stage 0 loads on accept, later stages shift every cycle.
module dm_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_b,
  input  logic              ld_en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage_q [RD_LAT];
  logic [DATA_W-1:0] stage_d [RD_LAT];

  always_comb begin
    for (int i = 0; i < RD_LAT; i++) stage_d[i] = stage_q[i];
    if (ld_en) stage_d[0] = d;
    for (int i = 1; i < RD_LAT; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[RD_LAT-1];

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder: word array with byte-lane write merge, post-reset zeroing sweep
// and configurable read latency.
//
// state    | meaning
// ST_INIT  | zeroing sweep, one word per cycle, accesses ignored
// ST_READY | ready=1, one access accepted per cycle when CS=1
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1
) (
  input logic    clk,
  input logic    rst,
  dm_mem_if.slave bus
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic                    accept;
  logic                    is_write;
  logic [DM_MAX_LANES-1:0] web_full;
  logic [DM_MAX_W-1:0]     merged_full;
  logic [DATA_W-1:0]       merged;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       pipe_q;

  always_comb begin
    web_full = '1;
    web_full[LANES-1:0] = bus.WEB;
  end

  // Write-first: the merged word is both what gets stored and what stage 0 captures.
  assign merged_full = lane_merge(DM_MAX_W'(mem[bus.A]), DM_MAX_W'(bus.DI), web_full);
  assign merged      = merged_full[DATA_W-1:0];

  generate
    if (DATA_W < int'(DM_MAX_W)) begin : g_pad
      logic [int'(DM_MAX_W)-DATA_W-1:0] merged_unused;
      assign merged_unused = merged_full[DM_MAX_W-1:DATA_W];
    end
  endgenerate

  assign accept   = bus.CS & ready_q;
  assign is_write = (web_full != WEB_READ);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_addr  = bus.A;
    mem_wdata = merged;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      ST_READY: begin
        ready_d = 1'b1;
        mem_we  = accept & is_write;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Contents survive reset; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_addr] <= mem_wdata;
  end

  dm_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .clr_b (rst),
    .ld_en (accept),
    .d     (merged),
    .q     (pipe_q)
  );

  assign bus.ready = ready_q;
  assign bus.DO    = bus.OE ? pipe_q : '0;

endmodule
